mem_port_arbiter: RTL

//  Shares the single external memory port between instruction fetch (IF) and load/store (MEM stage).

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one external memory port between instruction fetch (IF) and
// load/store (LS). One transaction is in flight at a time: arbitrate in
// IDLE, present the request in ISSUE, collect the response in WAIT.
//
// Handshake semantics (all ports): a requester holds req and its fields
// stable until it sees its gnt pulse. gnt, rvalid and err are single-cycle
// pulses. On the memory side, mem_req_o and its fields stay stable until
// the cycle in which mem_gnt_i is high. The response is taken from
// mem_rvalid_i only while in WAIT.
//
// Note: rst_n is an active-high synchronous reset despite its name.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_wmask_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o,
    output logic                busy_o,
    output logic [1:0]          dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    // owner of the current transaction; between transactions it is the
    // last granted requester, which is what the tie-break looks at
    logic        owner;
    logic        is_store;
    logic [15:0] wait_cnt;

    logic        arb_valid;
    logic        pick_ls;
    logic        timeout_hit;
    logic        done;
    logic [DATA_W-1:0] resp_data;

    // Arbitration: single requester wins; on a tie the one not granted last wins
    always_comb begin
        arb_valid = !rst_n && (state == ST_IDLE) && (if_req_i || ls_req_i);
        pick_ls   = ls_req_i && (!if_req_i || (owner == OWNER_IF));
    end

    // Completion detection: real response has priority over a timeout
    always_comb begin
        timeout_hit = (state == ST_WAIT) && !mem_rvalid_i && (wait_cnt == TIMEOUT_CNT);
        done        = !rst_n && (state == ST_WAIT) && (mem_rvalid_i || timeout_hit);
        resp_data   = (mem_rvalid_i && !is_store) ? mem_rdata_i : '0;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: if (mem_gnt_i) state_nxt = ST_WAIT;
            ST_WAIT:  if (mem_rvalid_i || timeout_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, ownership, latched memory fields and the WAIT timeout counter
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= ST_IDLE;
            owner       <= OWNER_IF;
            is_store    <= 1'b0;
            wait_cnt    <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
        end else begin
            state <= state_nxt;
            if (arb_valid) begin
                owner       <= pick_ls;
                is_store    <= pick_ls && ls_we_i;
                mem_we_o    <= pick_ls && ls_we_i;
                mem_addr_o  <= pick_ls ? ls_addr_i : if_addr_i;
                mem_wdata_o <= (pick_ls && ls_we_i) ? ls_wdata_i : '0;
                mem_wmask_o <= (pick_ls && ls_we_i) ? ls_wmask_i : '0;
            end
            if ((state == ST_ISSUE) && mem_gnt_i) begin
                // request accepted: fields are no longer needed on the bus
                wait_cnt    <= '0;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= '0;
                mem_wdata_o <= '0;
                mem_wmask_o <= '0;
            end else if ((state == ST_WAIT) && !mem_rvalid_i && (wait_cnt != TIMEOUT_CNT)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // Output decode: only the owner sees rvalid/rdata, everything quiet in reset
    always_comb begin
        if_gnt_o    = arb_valid && !pick_ls;
        ls_gnt_o    = arb_valid && pick_ls;
        if_rvalid_o = done && (owner == OWNER_IF);
        ls_rvalid_o = done && (owner == OWNER_LS);
        if_rdata_o  = if_rvalid_o ? resp_data : '0;
        ls_rdata_o  = ls_rvalid_o ? resp_data : '0;
        err_o       = done && timeout_hit;
        mem_req_o   = !rst_n && (state == ST_ISSUE);
        busy_o      = !rst_n && (state != ST_IDLE);
        dbg_state_o = state;
    end

endmodule
